instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Memory-side responder for the instruction fetch unit.
- A host DMA loads the program image over an AXI-Stream slave port into an N-deep, 32-bit instruction store.
- The block then serves fetch requests, given as PC address plus a request strobe, with a fixed-latency read and a one-cycle INSTR_DONE pulse that the fetch unit uses to latch INSTR_AXI.
- It sits between the host load path and the core front end, and also reports load status.

Parameters:
- N, 512, instruction store depth in words; must be a power of two.
- RD_LAT, 2, cycles from accepted FETCH_REQ to INSTR_DONE; legal range 1..4.

Ports:
- CLK  in  1  clock
- RSTN  in  1  synchronous, active-low reset
- S_TDATA  in  32  program word from host
- S_TVALID  in  1  host beat valid
- S_TLAST  in  1  last word of program image
- S_TREADY  out  1  block accepts beat
- RELOAD  in  1  pulse: discard program, return to EMPTY
- PC_AXI  in  $clog2(N)  fetch word address
- FETCH_REQ  in  1  fetch request strobe
- INSTR_AXI  out  32  fetched instruction
- INSTR_DONE  out  1  one-cycle pulse: INSTR_AXI valid
- PROG_LOADED  out  1  program resident, fetches accepted
- PROG_LEN  out  $clog2(N)+1  number of words loaded
- LOAD_ERR  out  1  sticky: image longer than N words
- ADDR_ERR  out  1  sticky: fetch at address >= PROG_LEN

Behaviour:
- Reset (RSTN=0 at a CLK edge):
  - State goes to EMPTY; write pointer wptr=0.
  - All outputs are 0, including S_TREADY, INSTR_AXI=0, PROG_LEN=0 and both sticky errors.
  - Store contents are not cleared.
  - A reset during LOADING or FETCH aborts it; no INSTR_DONE is produced for an aborted fetch.
- FSM states: EMPTY, LOADING, DRAIN, READY, FETCH.
- S_TREADY is 1 in EMPTY, LOADING and DRAIN, and 0 otherwise. It is a registered output and is 0 in the first cycle after reset.
- EMPTY:
  - An accepted beat (S_TVALID & S_TREADY) writes mem[0] and sets wptr=1.
  - With S_TLAST=1: go to READY with PROG_LEN=1.
  - With S_TLAST=0: go to LOADING.
- LOADING:
  - Each accepted beat writes mem[wptr] and increments wptr.
  - S_TLAST on an accepted beat: go to READY with PROG_LEN = wptr+1.
  - Beat accepted at wptr=N-1 without S_TLAST: the word is written, PROG_LEN=N, LOAD_ERR=1, go to DRAIN.
- DRAIN:
  - Beats are accepted and discarded.
  - The accepted beat with S_TLAST=1 moves the block to READY.
- PROG_LOADED is 1 only in READY and FETCH.
- READY:
  - FETCH_REQ=1 captures PC_AXI and the block goes to FETCH.
  - If RELOAD=1 in the same cycle, RELOAD wins: the request is dropped, the block goes to EMPTY, wptr=0, PROG_LEN=0 and PROG_LOADED=0. Sticky errors are kept.
- FETCH:
  - For a request accepted at edge t, INSTR_DONE=1 during the cycle after edge t+RD_LAT, for exactly one cycle.
  - INSTR_AXI is updated at the same edge as INSTR_DONE.
  - The state returns to READY at that edge, so a FETCH_REQ asserted while INSTR_DONE=1 is accepted, giving a back-to-back throughput of one fetch per RD_LAT cycles.
  - FETCH_REQ and RELOAD are ignored while in FETCH.
- Out-of-range fetch (captured address >= PROG_LEN): INSTR_AXI=32'h0000_0000, ADDR_ERR=1 (sticky), and INSTR_DONE still pulses.
- INSTR_AXI holds its last value between fetches.
- FETCH_REQ in EMPTY, LOADING or DRAIN is ignored: no response and no error.
- Sticky errors clear only on reset.
- Read path: the store is a single-port-write, single-port-read RAM inferable as BRAM. Read register stages are padded to RD_LAT.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44 with S_TLAST on the 4th -> PROG_LOADED=1, PROG_LEN=4. FETCH_REQ with PC_AXI=2 at edge t -> INSTR_AXI=0x33 and INSTR_DONE=1 exactly one cycle after edge t+2; INSTR_DONE is 0 on every other cycle.
- Back-to-back: FETCH_REQ held high with PC_AXI stepping 0,1,2,3 on each INSTR_DONE -> INSTR_DONE every 2 cycles returning 0x11,0x22,0x33,0x44. Requests raised mid-FETCH are not double-counted.
- Overflow with N=8: stream 10 words, S_TLAST on the 10th -> words 0..7 stored, PROG_LEN=8, LOAD_ERR=1, S_TREADY high through beat 10, then READY.
- Out of range: after a 4-word load, fetch PC_AXI=5 -> INSTR_AXI=0, ADDR_ERR=1, INSTR_DONE pulses. A following fetch of PC=1 returns 0x22 and ADDR_ERR stays 1.
- RELOAD and FETCH_REQ in the same READY cycle -> no INSTR_DONE; state EMPTY, PROG_LEN=0, S_TREADY=1. A new 2-word load then succeeds.
- RSTN=0 mid-load (after 2 of 5 beats) and mid-fetch -> next cycle all outputs 0 and no INSTR_DONE. Fetches are ignored until a fresh load completes.

Source files
------------

// File: rtl/instr_mem_responder_if.sv
// Host load stream, fetch request/response and load status bundle for instr_mem_responder.
interface instr_mem_responder_if #(
  parameter int unsigned N = 512
);
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned LW = AW + 1;

  logic [31:0]   S_TDATA;
  logic          S_TVALID;
  logic          S_TLAST;
  logic          S_TREADY;
  logic          RELOAD;
  logic [AW-1:0] PC_AXI;
  logic          FETCH_REQ;
  logic [31:0]   INSTR_AXI;
  logic          INSTR_DONE;
  logic          PROG_LOADED;
  logic [LW-1:0] PROG_LEN;
  logic          LOAD_ERR;
  logic          ADDR_ERR;

  modport slave (
    input  S_TDATA, S_TVALID, S_TLAST, RELOAD, PC_AXI, FETCH_REQ,
    output S_TREADY, INSTR_AXI, INSTR_DONE, PROG_LOADED, PROG_LEN, LOAD_ERR, ADDR_ERR
  );

  modport master (
    output S_TDATA, S_TVALID, S_TLAST, RELOAD, PC_AXI, FETCH_REQ,
    input  S_TREADY, INSTR_AXI, INSTR_DONE, PROG_LOADED, PROG_LEN, LOAD_ERR, ADDR_ERR
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction store: loaded from a host AXI-Stream, then serves fixed-latency fetches.
module instr_mem_responder #(
  parameter int unsigned N      = 512,
  parameter int unsigned RD_LAT = 2
) (
  input logic                  CLK,
  input logic                  RSTN,
  instr_mem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 2;

  typedef enum logic [2:0] {EMPTY, LOADING, DRAIN, READY, FETCH} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] prog_len_q, prog_len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;
  logic          addr_err_q, addr_err_d;
  logic          tready_q, loaded_q;
  logic          beat, wr_en, take_req, last_cyc;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   rd_q;
  logic [31:0]   mem [N];

  assign bus.S_TREADY    = tready_q;
  assign bus.INSTR_AXI   = instr_q;
  assign bus.INSTR_DONE  = done_q;
  assign bus.PROG_LOADED = loaded_q;
  assign bus.PROG_LEN    = prog_len_q;
  assign bus.LOAD_ERR    = load_err_q;
  assign bus.ADDR_ERR    = addr_err_q;

  // Next-state and next-output logic; the last FETCH cycle can accept a new request.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    done_d     = 1'b0;
    load_err_d = load_err_q;
    addr_err_d = addr_err_q;
    wr_en      = 1'b0;
    wr_addr    = wptr_q[AW-1:0];
    take_req   = 1'b0;
    beat       = bus.S_TVALID & tready_q;
    last_cyc   = (state_q == FETCH) && (cnt_q == CW'(RD_LAT - 1));

    case (state_q)
      EMPTY: begin
        if (beat) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          wptr_d  = LW'(1);
          if (bus.S_TLAST) begin
            state_d    = READY;
            prog_len_d = LW'(1);
          end else begin
            state_d = LOADING;
          end
        end
      end
      LOADING: begin
        if (beat) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + LW'(1);
          if (bus.S_TLAST) begin
            state_d    = READY;
            prog_len_d = wptr_q + LW'(1);
          end else if (wptr_q == LW'(N - 1)) begin
            state_d    = DRAIN;
            prog_len_d = LW'(N);
            load_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat && bus.S_TLAST) state_d = READY;
      end
      READY: begin
        if (bus.RELOAD) begin
          state_d    = EMPTY;
          wptr_d     = '0;
          prog_len_d = '0;
        end else if (bus.FETCH_REQ) begin
          take_req = 1'b1;
        end
      end
      FETCH: begin
        if (last_cyc) begin
          done_d   = 1'b1;
          state_d  = READY;
          take_req = bus.FETCH_REQ;
          if ({1'b0, addr_q} >= prog_len_q) begin
            instr_d    = '0;
            addr_err_d = 1'b1;
          end else begin
            instr_d = rd_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = EMPTY;
    endcase

    if (take_req) begin
      state_d = FETCH;
      addr_d  = bus.PC_AXI;
      cnt_d   = '0;
    end

    // Read the incoming PC on the accept edge so data is ready even at RD_LAT=1.
    rd_addr = ((state_q == READY) || last_cyc) ? bus.PC_AXI : addr_q;
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= EMPTY;
      wptr_q     <= '0;
      prog_len_q <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      instr_q    <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      addr_err_q <= 1'b0;
      tready_q   <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      addr_err_q <= addr_err_d;
      tready_q   <= (state_d == EMPTY) || (state_d == LOADING) || (state_d == DRAIN);
      loaded_q   <= (state_d == READY) || (state_d == FETCH);
    end
  end

  // Store write port; contents survive reset but reset blocks a write.
  always_ff @(posedge CLK) begin
    if (wr_en && RSTN) mem[wr_addr] <= bus.S_TDATA;
  end

  // Synchronous read port.
  always_ff @(posedge CLK) begin
    rd_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder (N=8, RD_LAT=2).
module tb_instr_mem_responder;
  localparam int unsigned N      = 8;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned AW     = $clog2(N);

  typedef struct {
    logic [31:0] data;
    logic        aerr;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  exp_t        sb[$];
  logic [31:0] img [16];

  instr_mem_responder_if #(.N(N)) bus ();

  instr_mem_responder #(.N(N), .RD_LAT(RD_LAT)) dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  // Response monitor: every INSTR_DONE must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.INSTR_DONE) begin
      if (sb.size() == 0) begin
        check("spurious_done", bus.INSTR_DONE, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("instr_axi", bus.INSTR_AXI, e.data);
        check("done_cycle", cyc, e.due);
        check("addr_err_at_done", bus.ADDR_ERR, e.aerr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] data, input logic aerr);
    exp_t e;
    e.data = data;
    e.aerr = aerr;
    e.due  = cyc + RD_LAT;
    sb.push_back(e);
  endtask

  task automatic check_zero();
    check("rst_tready", bus.S_TREADY, 1'b0);
    check("rst_loaded", bus.PROG_LOADED, 1'b0);
    check("rst_len", bus.PROG_LEN, 0);
    check("rst_instr", bus.INSTR_AXI, 0);
    check("rst_done", bus.INSTR_DONE, 1'b0);
    check("rst_load_err", bus.LOAD_ERR, 1'b0);
    check("rst_addr_err", bus.ADDR_ERR, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_zero();
    rstn = 1'b1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic chk);
    int unsigned n;
    n = 0;
    @(negedge clk);
    bus.S_TDATA  = d;
    bus.S_TVALID = 1'b1;
    bus.S_TLAST  = last;
    if (chk) check("tready_beat", bus.S_TREADY, 1'b1);
    while (!bus.S_TREADY && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!bus.S_TREADY) check("tready_timeout", bus.S_TREADY, 1'b1);
    @(posedge clk);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) send_beat(img[i], i == n - 1, i != 0);
    @(negedge clk);
    bus.S_TVALID = 1'b0;
    bus.S_TLAST  = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] pc, input logic [31:0] exp, input logic aerr);
    @(negedge clk);
    bus.PC_AXI    = pc;
    bus.FETCH_REQ = 1'b1;
    @(posedge clk);
    #1;
    push_exp(exp, aerr);
    @(negedge clk);
    bus.FETCH_REQ = 1'b0;
    repeat (RD_LAT + 1) @(negedge clk);
  endtask

  task automatic ignored_req(input int n);
    @(negedge clk);
    bus.PC_AXI    = '0;
    bus.FETCH_REQ = 1'b1;
    repeat (n) @(negedge clk);
    bus.FETCH_REQ = 1'b0;
    repeat (RD_LAT + 1) @(negedge clk);
  endtask

  initial begin
    bus.S_TDATA   = '0;
    bus.S_TVALID  = 1'b0;
    bus.S_TLAST   = 1'b0;
    bus.RELOAD    = 1'b0;
    bus.PC_AXI    = '0;
    bus.FETCH_REQ = 1'b0;

    // Reset values, then S_TREADY rises one cycle later.
    do_reset();
    @(negedge clk);
    check("tready_after_reset", bus.S_TREADY, 1'b1);

    // Basic 4-word load and single fetch.
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    load(4);
    check("loaded_4", bus.PROG_LOADED, 1'b1);
    check("len_4", bus.PROG_LEN, 4);
    check("tready_ready", bus.S_TREADY, 1'b0);
    fetch(AW'(2), 32'h33, 1'b0);

    // Back-to-back fetches with FETCH_REQ held high.
    @(negedge clk);
    bus.PC_AXI    = '0;
    bus.FETCH_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      push_exp(img[i], 1'b0);
      @(negedge clk);
      if (i < 3) begin
        bus.PC_AXI = AW'(i + 1);
        repeat (RD_LAT - 1) begin
          @(posedge clk);
          @(negedge clk);
        end
      end else begin
        bus.FETCH_REQ = 1'b0;
      end
    end
    repeat (RD_LAT + 2) @(negedge clk);

    // Out-of-range fetch, then a good fetch with sticky ADDR_ERR.
    fetch(AW'(5), 32'h0, 1'b1);
    check("addr_err_sticky", bus.ADDR_ERR, 1'b1);
    fetch(AW'(1), 32'h22, 1'b1);

    // RELOAD beats FETCH_REQ in the same READY cycle.
    @(negedge clk);
    bus.RELOAD    = 1'b1;
    bus.FETCH_REQ = 1'b1;
    bus.PC_AXI    = '0;
    @(negedge clk);
    bus.RELOAD    = 1'b0;
    bus.FETCH_REQ = 1'b0;
    check("reload_len", bus.PROG_LEN, 0);
    check("reload_loaded", bus.PROG_LOADED, 1'b0);
    check("reload_tready", bus.S_TREADY, 1'b1);
    check("reload_keeps_addr_err", bus.ADDR_ERR, 1'b1);
    repeat (4) @(negedge clk);
    img[0] = 32'hA0; img[1] = 32'hA1;
    load(2);
    check("len_2", bus.PROG_LEN, 2);
    check("loaded_2", bus.PROG_LOADED, 1'b1);
    fetch(AW'(1), 32'hA1, 1'b1);
    fetch(AW'(0), 32'hA0, 1'b1);

    // Overflow: 10 words into an 8-deep store.
    do_reset();
    for (int i = 0; i < 10; i++) img[i] = 32'h100 + 32'(i);
    load(10);
    check("ovf_len", bus.PROG_LEN, N);
    check("ovf_load_err", bus.LOAD_ERR, 1'b1);
    check("ovf_loaded", bus.PROG_LOADED, 1'b1);
    check("ovf_tready", bus.S_TREADY, 1'b0);
    check("ovf_addr_err", bus.ADDR_ERR, 1'b0);
    fetch(AW'(0), 32'h100, 1'b0);
    fetch(AW'(7), 32'h107, 1'b0);

    // Reset in the middle of a load.
    do_reset();
    for (int i = 0; i < 5; i++) img[i] = 32'h200 + 32'(i);
    send_beat(img[0], 1'b0, 1'b0);
    send_beat(img[1], 1'b0, 1'b1);
    @(negedge clk);
    bus.S_TVALID = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_zero();
    rstn = 1'b1;
    ignored_req(4);
    check("midload_not_loaded", bus.PROG_LOADED, 1'b0);
    for (int i = 0; i < 3; i++) img[i] = 32'h300 + 32'(i);
    load(3);
    check("len_3", bus.PROG_LEN, 3);
    fetch(AW'(2), 32'h302, 1'b0);

    // Reset in the middle of a fetch: no response may follow.
    @(negedge clk);
    bus.PC_AXI    = AW'(1);
    bus.FETCH_REQ = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.FETCH_REQ = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_zero();
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    ignored_req(3);
    check("midfetch_not_loaded", bus.PROG_LOADED, 1'b0);
    img[0] = 32'h55;
    load(1);
    check("len_1", bus.PROG_LEN, 1);
    fetch(AW'(0), 32'h55, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
